// File: rtl/slice_scheduler.sv
// slice_scheduler: sequences one rotational slice on the HUB75 chain.
//
// A new angle on dtheta_in starts a slice. The slice walks scan rows 0..SCAN_RATE-1 and issues
// one request per row to the frame manager. It waits for the output driver's row_done_in
// before it issues the next row. An angle that arrives mid-slice is held as a single pending
// angle, where the newest overwrites any older one, and it is counted as an overrun. A per-row
// watchdog abandons a slice when the driver hangs.
//
// Ports:
//   clk_in       system clock, rising edge
//   rst_in       asynchronous active-low reset
//   enable_in    permits new slices to start; low also drops any pending angle
//   dtheta_in    current angle from the angle tracker
//   req_valid    row request valid (held until accepted)
//   req_theta    angle of the requested row
//   req_row      scan row of the request
//   req_ready    frame manager accepts the request
//   row_done_in  one-cycle pulse: driver has latched the row
//   slice_done   one-cycle pulse: slice completed normally
//   busy         high while a slice is in progress
//   overrun_cnt  saturating count of angle changes seen mid-slice
//   timeout_flag sticky watchdog abort indicator
module slice_scheduler #(
  parameter int unsigned ROTATIONAL_RES = 1024,
  parameter int unsigned SCAN_RATE      = 32,
  parameter int unsigned ROW_TIMEOUT    = 4096,
  localparam int unsigned TW  = $clog2(ROTATIONAL_RES),
  localparam int unsigned RW  = $clog2(SCAN_RATE),
  localparam int unsigned WDW = $clog2(ROW_TIMEOUT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          enable_in,
  input  logic [TW-1:0] dtheta_in,
  output logic          req_valid,
  output logic [TW-1:0] req_theta,
  output logic [RW-1:0] req_row,
  input  logic          req_ready,
  input  logic          row_done_in,
  output logic          slice_done,
  output logic          busy,
  output logic [7:0]    overrun_cnt,
  output logic          timeout_flag
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   prev_theta_q;
  logic [TW-1:0]   cur_theta_q, cur_theta_d;
  logic [RW-1:0]   row_q, row_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            pending_valid_q, pending_valid_d;
  logic [TW-1:0]   pending_theta_q, pending_theta_d;
  logic [7:0]      overrun_q, overrun_d;
  logic            timeout_q, timeout_d;
  logic            done_q, done_d;

  logic            change;
  logic            start_ok;
  logic            take_pending;
  logic [TW-1:0]   start_theta;
  logic            mid_change;

  assign change = (dtheta_in != prev_theta_q);

  // A fresh angle wins over the pending one. The pending angle is used only when nothing new
  // arrives in this cycle.
  assign start_ok     = enable_in && (change || pending_valid_q);
  assign take_pending = enable_in && !change && pending_valid_q;
  assign start_theta  = change ? dtheta_in : pending_theta_q;

  always_comb begin
    state_d         = state_q;
    cur_theta_d     = cur_theta_q;
    row_d           = row_q;
    wdog_d          = wdog_q;
    pending_valid_d = pending_valid_q;
    pending_theta_d = pending_theta_q;
    overrun_d       = overrun_q;
    timeout_d       = timeout_q;
    done_d          = 1'b0;
    mid_change      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d     = StIssue;
          cur_theta_d = start_theta;
          row_d       = '0;
          if (take_pending) pending_valid_d = 1'b0;
        end
      end
      StIssue: begin
        mid_change = change;
        if (req_ready) begin
          state_d = StWait;
          wdog_d  = '0;
        end
      end
      StWait: begin
        if (row_done_in) begin
          if (row_q != RW'(SCAN_RATE - 1)) begin
            row_d      = row_q + RW'(1);
            state_d    = StIssue;
            mid_change = change;
          end else begin
            // Final row: a change in this cycle becomes the next slice, not an overrun.
            done_d = 1'b1;
            if (start_ok) begin
              state_d     = StIssue;
              cur_theta_d = start_theta;
              row_d       = '0;
              if (take_pending) pending_valid_d = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end
        end else if (wdog_q == WDW'(ROW_TIMEOUT - 1)) begin
          timeout_d  = 1'b1;
          state_d    = StIdle;
          mid_change = change;
        end else begin
          wdog_d     = wdog_q + WDW'(1);
          mid_change = change;
        end
      end
      default: state_d = StIdle;
    endcase

    if (mid_change) begin
      pending_theta_d = dtheta_in;
      pending_valid_d = 1'b1;
      if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
    end

    if (!enable_in) pending_valid_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q         <= StIdle;
      prev_theta_q    <= '0;
      cur_theta_q     <= '0;
      row_q           <= '0;
      wdog_q          <= '0;
      pending_valid_q <= 1'b0;
      pending_theta_q <= '0;
      overrun_q       <= '0;
      timeout_q       <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_theta_q    <= dtheta_in;
      cur_theta_q     <= cur_theta_d;
      row_q           <= row_d;
      wdog_q          <= wdog_d;
      pending_valid_q <= pending_valid_d;
      pending_theta_q <= pending_theta_d;
      overrun_q       <= overrun_d;
      timeout_q       <= timeout_d;
      done_q          <= done_d;
    end
  end

  assign req_valid    = (state_q == StIssue);
  assign req_theta    = cur_theta_q;
  assign req_row      = row_q;
  assign busy         = (state_q != StIdle);
  assign slice_done   = done_q;
  assign overrun_cnt  = overrun_q;
  assign timeout_flag = timeout_q;

endmodule
